// File: rtl/rvv_pkg.sv
// rvv_pkg: definitions shared by the vector ALU sequencer and its helpers.
//   - funct6 opcode encodings for the supported integer arith/logic ops
//   - op_type encodings (VV / VX / VI)
//   - sequencer FSM state encoding
//   - SEW decode helpers
package rvv_pkg;

    localparam logic [5:0] VADD  = 6'b000000;
    localparam logic [5:0] VSUB  = 6'b000010;
    localparam logic [5:0] VRSUB = 6'b000011;
    localparam logic [5:0] VAND  = 6'b001001;
    localparam logic [5:0] VOR   = 6'b001010;
    localparam logic [5:0] VXOR  = 6'b001011;

    localparam logic [2:0] OPT_VV = 3'b001;
    localparam logic [2:0] OPT_VX = 3'b010;
    localparam logic [2:0] OPT_VI = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_e;

    // Element width in bits for a vsew code; 0 for reserved codes.
    function automatic logic [6:0] sew_bits(input logic [2:0] vsew);
        case (vsew)
            3'd0:    return 7'd8;
            3'd1:    return 7'd16;
            3'd2:    return 7'd32;
            3'd3:    return 7'd64;
            default: return 7'd0;
        endcase
    endfunction

    function automatic logic sew_legal(input logic [2:0] vsew);
        return (vsew <= 3'd3);
    endfunction

endpackage

// File: rtl/rvv_tail_mask.sv
// rvv_tail_mask: per-bit write enable for one lane-sized chunk of the
// destination image. Bit b is enabled when (idx + b) lies inside the active
// body (below total_bits); bits past the body keep their old value.
// Ports:
//   idx_i        chunk start bit index within the vector register
//   total_bits_i number of body bits (vl_eff * SEW)
//   mask_o       L-bit write mask, combinational
module rvv_tail_mask #(
    parameter int unsigned L = 8
) (
    input  logic [9:0]   idx_i,
    input  logic [16:0]  total_bits_i,
    output logic [L-1:0] mask_o
);

    always_comb begin
        mask_o = '0;
        for (int unsigned b = 0; b < L; b++) begin
            mask_o[b] = (({7'd0, idx_i} + 17'(b)) < total_bits_i);
        end
    end

endmodule

// File: rtl/rvv_alu_seq.sv
// rvv_alu_seq: sequencer for one rvv_alu instance. Accepts one vector
// arith/logic op, then steps the ALU one lane chunk per cycle over vl*SEW
// bits, merging each lane result into a VLEN-bit destination image with
// tail-undisturbed semantics.
// Handshake: an op is accepted on a clock edge where start=1 and ready=1;
// start while ready=0 is dropped, never queued. done pulses for one cycle
// when vd_out is final; err pulses together with done for a reserved vsew.
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   start / ready          op request / idle indicator
//   opcode, op_type, vsew, vl, vd_old   op fields, latched on accept
//   alu_run, alu_opcode, alu_op_type, alu_vsew, alu_nb_lanes,
//   alu_index, alu_in_reg_off           ALU control
//   alu_vd                 ALU result, same cycle
//   vd_out, done, err      destination image and completion pulses
//   dbg_state              current FSM state
module rvv_alu_seq
    import rvv_pkg::*;
#(
    parameter int unsigned VLEN       = 128,
    parameter int unsigned LANE_WIDTH = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic            ready,
    input  logic [5:0]      opcode,
    input  logic [2:0]      op_type,
    input  logic [2:0]      vsew,
    input  logic [9:0]      vl,
    input  logic [VLEN-1:0] vd_old,
    output logic            alu_run,
    output logic [5:0]      alu_opcode,
    output logic [2:0]      alu_op_type,
    output logic [2:0]      alu_vsew,
    output logic [1:0]      alu_nb_lanes,
    output logic [9:0]      alu_index,
    output logic [3:0]      alu_in_reg_off,
    input  logic [63:0]     alu_vd,
    output logic [VLEN-1:0] vd_out,
    output logic            done,
    output logic            err,
    output seq_state_e      dbg_state
);

    localparam int unsigned L  = 1 << LANE_WIDTH;
    localparam int unsigned IW = $clog2(VLEN);

    seq_state_e      state_q, state_d;
    logic [5:0]      opcode_q, opcode_d;
    logic [2:0]      op_type_q, op_type_d;
    logic [2:0]      vsew_q, vsew_d;
    logic [16:0]     total_q, total_d;
    logic [3:0]      cpe_m1_q, cpe_m1_d;
    logic [9:0]      idx_q, idx_d;
    logic [3:0]      off_q, off_d;
    logic [VLEN-1:0] vd_q, vd_d;
    logic            err_q, err_d;

    // Decode of the incoming request, used only on accept.
    logic [6:0]  sew_in;
    logic [16:0] prod_in;
    logic [16:0] total_in;
    logic [6:0]  cpe_in;
    logic [3:0]  cpe_m1_in;

    logic [L-1:0]  mask;
    logic [L-1:0]  lane_old;
    logic [L-1:0]  lane_new;
    logic [IW-1:0] idx_bit;
    logic          last_chunk;
    logic          unused_alu_vd;

    assign sew_in  = sew_bits(vsew);
    // vl*SEW is formed at full width first; clamping the product to VLEN is
    // the same as clamping vl to VLMAX because VLEN is a multiple of SEW.
    assign prod_in   = 17'(vl) * 17'(sew_in);
    assign total_in  = (prod_in > 17'(VLEN)) ? 17'(VLEN) : prod_in;
    assign cpe_in    = sew_in >> LANE_WIDTH;
    assign cpe_m1_in = (cpe_in == 7'd0) ? 4'd0 : 4'(cpe_in - 7'd1);

    assign idx_bit    = idx_q[IW-1:0];
    assign lane_old   = vd_q[idx_bit +: L];
    assign lane_new   = alu_vd[L-1:0];
    assign last_chunk = (({7'd0, idx_q} + 17'(L)) >= total_q);
    assign unused_alu_vd = ^alu_vd;

    rvv_tail_mask #(.L(L)) u_tail_mask (
        .idx_i        (idx_q),
        .total_bits_i (total_q),
        .mask_o       (mask)
    );

    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        op_type_d = op_type_q;
        vsew_d    = vsew_q;
        total_d   = total_q;
        cpe_m1_d  = cpe_m1_q;
        idx_d     = idx_q;
        off_d     = off_q;
        vd_d      = vd_q;
        err_d     = err_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    opcode_d  = opcode;
                    op_type_d = op_type;
                    vsew_d    = vsew;
                    total_d   = total_in;
                    cpe_m1_d  = cpe_m1_in;
                    idx_d     = 10'd0;
                    off_d     = 4'd0;
                    vd_d      = vd_old;
                    err_d     = !sew_legal(vsew);
                    // Nothing to compute: finish without touching the ALU.
                    if (!sew_legal(vsew) || (total_in == 17'd0)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                vd_d[idx_bit +: L] = (lane_new & mask) | (lane_old & ~mask);
                idx_d = idx_q + 10'(L);
                // off wraps at each element boundary so the ALU drops its carry.
                off_d = (off_q == cpe_m1_q) ? 4'd0 : off_q + 4'd1;
                if (last_chunk) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            opcode_q  <= '0;
            op_type_q <= '0;
            vsew_q    <= '0;
            total_q   <= '0;
            cpe_m1_q  <= '0;
            idx_q     <= '0;
            off_q     <= '0;
            vd_q      <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            op_type_q <= op_type_d;
            vsew_q    <= vsew_d;
            total_q   <= total_d;
            cpe_m1_q  <= cpe_m1_d;
            idx_q     <= idx_d;
            off_q     <= off_d;
            vd_q      <= vd_d;
            err_q     <= err_d;
        end
    end

    assign ready          = (state_q == ST_IDLE);
    assign alu_run        = (state_q == ST_RUN);
    assign done           = (state_q == ST_DONE);
    assign err            = (state_q == ST_DONE) && err_q;
    assign alu_opcode     = opcode_q;
    assign alu_op_type    = op_type_q;
    assign alu_vsew       = vsew_q;
    assign alu_nb_lanes   = 2'd0;
    assign alu_index      = alu_run ? idx_q : 10'd0;
    assign alu_in_reg_off = alu_run ? off_q : 4'd0;
    assign vd_out         = vd_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_rvv_alu_seq.sv
module tb_rvv_alu_seq;
    import rvv_pkg::*;

    localparam int VLEN = 128;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset;
    logic            start;
    logic            ready;
    logic [5:0]      opcode;
    logic [2:0]      op_type;
    logic [2:0]      vsew;
    logic [9:0]      vl;
    logic [VLEN-1:0] vd_old;
    logic            alu_run;
    logic [5:0]      alu_opcode;
    logic [2:0]      alu_op_type;
    logic [2:0]      alu_vsew;
    logic [1:0]      alu_nb_lanes;
    logic [9:0]      alu_index;
    logic [3:0]      alu_in_reg_off;
    logic [63:0]     alu_vd;
    logic [VLEN-1:0] vd_out;
    logic            done;
    logic            err;
    seq_state_e      dbg_state;

    rvv_alu_seq #(.VLEN(VLEN), .LANE_WIDTH(3)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .ready          (ready),
        .opcode         (opcode),
        .op_type        (op_type),
        .vsew           (vsew),
        .vl             (vl),
        .vd_old         (vd_old),
        .alu_run        (alu_run),
        .alu_opcode     (alu_opcode),
        .alu_op_type    (alu_op_type),
        .alu_vsew       (alu_vsew),
        .alu_nb_lanes   (alu_nb_lanes),
        .alu_index      (alu_index),
        .alu_in_reg_off (alu_in_reg_off),
        .alu_vd         (alu_vd),
        .vd_out         (vd_out),
        .done           (done),
        .err            (err),
        .dbg_state      (dbg_state)
    );

    // ---------------- 8-bit lane ALU stand-in ----------------
    // Register-file operands for the op in flight; carry chains across the
    // chunks of one element and restarts whenever in_reg_off is 0.
    logic [VLEN-1:0] cur_vs2, cur_vs1;
    logic            cout_q = 1'b0;
    logic [6:0]      alu_bi;
    logic [7:0]      alu_a, alu_b;
    logic            alu_cin;
    logic [8:0]      alu_s;

    always_comb begin
        alu_bi  = alu_index[6:0];
        alu_a   = cur_vs2[alu_bi +: 8];
        alu_b   = cur_vs1[alu_bi +: 8];
        alu_cin = (alu_in_reg_off == 4'd0) ? (alu_opcode == VSUB) : cout_q;
        alu_s   = 9'd0;
        case (alu_opcode)
            VADD:    alu_s = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin};
            VSUB:    alu_s = {1'b0, alu_a} + {1'b0, ~alu_b} + {8'd0, alu_cin};
            VAND:    alu_s = {1'b0, alu_a & alu_b};
            VOR:     alu_s = {1'b0, alu_a | alu_b};
            VXOR:    alu_s = {1'b0, alu_a ^ alu_b};
            default: alu_s = 9'd0;
        endcase
        alu_vd = {56'd0, alu_s[7:0]};
    end

    always @(posedge clk) begin
        if (alu_run) cout_q <= alu_s[8];
    end

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    logic [VLEN-1:0] exp_q[$];
    int              lat_q[$];
    logic            err_exp_q[$];
    logic [3:0]      offs_q[$];

    task automatic chk(input string name, input logic [VLEN-1:0] act, input logic [VLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Element-wise reference: body elements get op(vs2, vs1), tail keeps old.
    function automatic logic [VLEN-1:0] model(input logic [5:0] op, input logic [2:0] vs,
                                               input logic [9:0] vln, input logic [VLEN-1:0] a_v,
                                               input logic [VLEN-1:0] b_v, input logic [VLEN-1:0] old);
        logic [VLEN-1:0] r;
        logic [63:0] a, b, y;
        int sew, n;
        r = old;
        if (vs > 3'd3) return r;
        sew = 8 << vs;
        n = int'(vln);
        if (n > VLEN / sew) n = VLEN / sew;
        for (int e = 0; e < n; e++) begin
            a = '0;
            b = '0;
            for (int j = 0; j < sew; j++) begin
                a[j] = a_v[e * sew + j];
                b[j] = b_v[e * sew + j];
            end
            case (op)
                VADD:    y = a + b;
                VSUB:    y = a - b;
                VAND:    y = a & b;
                VOR:     y = a | b;
                VXOR:    y = a ^ b;
                default: y = '0;
            endcase
            for (int j = 0; j < sew; j++) r[e * sew + j] = y[j];
        end
        return r;
    endfunction

    typedef struct {
        logic [5:0]      op;
        logic [2:0]      vsew;
        logic [9:0]      vl;
        logic [VLEN-1:0] vs2;
        logic [VLEN-1:0] vs1;
        logic [VLEN-1:0] old;
        int              lat;
        logic            exp_err;
    } vec_t;

    vec_t vecs[10];

    function automatic logic [VLEN-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- driver ----------------
    // Issues one op, pushes its expectations, then follows it to done.
    // poke_at > 0 pulses start (with unrelated fields) on that cycle of the run.
    task automatic run_op(input vec_t v, input int poke_at);
        int  cyc;
        int  runs;
        bit  got;
        @(negedge clk);
        chk("ready_before_start", {127'd0, ready}, 128'd1);
        opcode  = v.op;
        op_type = OPT_VV;
        vsew    = v.vsew;
        vl      = v.vl;
        vd_old  = v.old;
        cur_vs2 = v.vs2;
        cur_vs1 = v.vs1;
        start   = 1'b1;
        exp_q.push_back(model(v.op, v.vsew, v.vl, v.vs2, v.vs1, v.old));
        lat_q.push_back(v.lat);
        err_exp_q.push_back(v.exp_err);
        offs_q.delete();
        @(negedge clk);
        start  = 1'b0;
        opcode = 6'($urandom_range(0, 63));
        vsew   = 3'($urandom_range(0, 7));
        vl     = 10'($urandom_range(0, 1023));
        vd_old = rnd128();
        cyc  = 1;
        runs = 0;
        got  = 1'b0;
        while (cyc <= 100 && !got) begin
            start = (cyc == poke_at);
            if (alu_run) begin
                runs++;
                offs_q.push_back(alu_in_reg_off);
            end
            if (done) begin
                got = 1'b1;
                chk("vd_out", vd_out, exp_q.pop_front());
                chk("latency", 128'(cyc), 128'(lat_q.pop_front()));
                chk("err_with_done", {127'd0, err}, {127'd0, err_exp_q.pop_front()});
                chk("run_cycles", 128'(runs), 128'(v.lat - 1));
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=no_done required=done_within_100");
            void'(exp_q.pop_front());
            void'(lat_q.pop_front());
            void'(err_exp_q.pop_front());
        end
    endtask

    // ---------------- test ----------------
    initial begin
        int idle_runs;
        int idle_dones;
        vec_t v;

        reset   = 1'b1;
        start   = 1'b0;
        opcode  = '0;
        op_type = OPT_VV;
        vsew    = '0;
        vl      = '0;
        vd_old  = '0;
        cur_vs2 = '0;
        cur_vs1 = '0;

        // vector table
        for (int i = 0; i < 10; i++) begin
            vecs[i].old = rnd128();
            vecs[i].vs2 = rnd128();
            vecs[i].vs1 = rnd128();
            vecs[i].exp_err = 1'b0;
        end
        for (int i = 0; i < 16; i++) begin
            vecs[0].vs2[8 * i +: 8] = 8'(i);
            vecs[0].vs1[8 * i +: 8] = 8'd1;
        end
        vecs[0].op = VADD; vecs[0].vsew = 3'd0; vecs[0].vl = 10'd16;  vecs[0].lat = 17;
        vecs[1].op = VADD; vecs[1].vsew = 3'd2; vecs[1].vl = 10'd1;   vecs[1].lat = 5;
        vecs[1].vs2[31:0] = 32'h0000_00FF;
        vecs[1].vs1[31:0] = 32'h0000_0001;
        vecs[2].op = VSUB; vecs[2].vsew = 3'd1; vecs[2].vl = 10'd3;   vecs[2].lat = 7;
        for (int i = 0; i < 3; i++) begin
            vecs[2].vs2[16 * i +: 16] = 16'd5;
            vecs[2].vs1[16 * i +: 16] = 16'd7;
        end
        vecs[3].op = VADD; vecs[3].vsew = 3'd0; vecs[3].vl = 10'd0;   vecs[3].lat = 1;
        vecs[4].op = VADD; vecs[4].vsew = 3'd0; vecs[4].vl = 10'd200; vecs[4].lat = 17;
        vecs[5].op = VADD; vecs[5].vsew = 3'b101; vecs[5].vl = 10'd4; vecs[5].lat = 1;
        vecs[5].exp_err = 1'b1;
        vecs[6].op = VXOR; vecs[6].vsew = 3'd3; vecs[6].vl = 10'd2;   vecs[6].lat = 17;
        vecs[7].op = VAND; vecs[7].vsew = 3'd1; vecs[7].vl = 10'd5;   vecs[7].lat = 11;
        vecs[8].op = VOR;  vecs[8].vsew = 3'd2; vecs[8].vl = 10'd3;   vecs[8].lat = 13;
        vecs[9].op = VSUB; vecs[9].vsew = 3'd3; vecs[9].vl = 10'd1;   vecs[9].lat = 9;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", {127'd0, ready}, 128'd1);
        chk("rst_alu_run", {127'd0, alu_run}, 128'd0);
        chk("rst_done", {127'd0, done}, 128'd0);
        chk("rst_err", {127'd0, err}, 128'd0);
        chk("rst_vd_out", vd_out, 128'd0);
        chk("rst_alu_index", 128'(alu_index), 128'd0);
        chk("rst_in_reg_off", 128'(alu_in_reg_off), 128'd0);
        chk("rst_state", 128'(dbg_state), 128'(ST_IDLE));
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i], 0);
            if (i == 0) chk("sew8_byte5", 128'(vd_out[47:40]), 128'd6);
            if (i == 1) begin
                chk("sew32_low_word", 128'(vd_out[31:0]), 128'h100);
                chk("sew32_tail", {vd_out[127:32], 32'd0}, {vecs[1].old[127:32], 32'd0});
                chk("sew32_nchunks", 128'(offs_q.size()), 128'd4);
                for (int k = 0; k < 4 && k < offs_q.size(); k++)
                    chk("sew32_off_seq", 128'(offs_q[k]), 128'(k));
            end
            if (i == 2) chk("sew16_elem0", 128'(vd_out[15:0]), 128'hFFFE);
            if (i == 3) chk("vl0_vd_old", vd_out, vecs[3].old);
        end

        // reset while at chunk 5 of 16: abort without a done pulse
        v = vecs[0];
        @(negedge clk);
        opcode  = v.op;
        vsew    = v.vsew;
        vl      = v.vl;
        vd_old  = v.old;
        cur_vs2 = v.vs2;
        cur_vs1 = v.vs1;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre_abort_index", 128'(alu_index), 128'd40);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_ready", {127'd0, ready}, 128'd1);
        chk("abort_alu_run", {127'd0, alu_run}, 128'd0);
        chk("abort_done", {127'd0, done}, 128'd0);
        chk("abort_vd_out", vd_out, 128'd0);
        reset = 1'b0;
        idle_runs  = 0;
        idle_dones = 0;
        repeat (20) begin
            @(negedge clk);
            if (alu_run) idle_runs++;
            if (done) idle_dones++;
        end
        chk("abort_no_done", 128'(idle_dones), 128'd0);
        chk("abort_no_run", 128'(idle_runs), 128'd0);

        // fresh op after abort, with a start pulse during RUN that must be dropped
        run_op(vecs[0], 4);
        idle_runs = 0;
        repeat (10) begin
            @(negedge clk);
            if (alu_run) idle_runs++;
        end
        chk("ignored_start_no_run", 128'(idle_runs), 128'd0);
        chk("scoreboard_empty", 128'(exp_q.size()), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
